// File: rtl/cdc_pkg.sv
// Shared constants and elaboration helpers for the multi-bit CDC synchronizer.
// Provides the legal synchronizer depth range, a constant clog2 and the
// filter counter width calculation used by cdc_sync_chan.
package cdc_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 8;

    // Constant-evaluable ceil(log2(v)); returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Filter counter must hold 0..FILTER; never narrower than one bit so the
    // declaration stays legal even when FILTER is small.
    function automatic int cnt_width(input int filter);
        int w;
        w = clog2(filter + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit stages_legal(input int stages);
        return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
    endfunction

endpackage

// File: rtl/cdc_sync_chan.sv
// One synchronized channel: STAGES-deep flop chain, optional persistence
// filter, and registered edge detection producing rise/fall/change pulses.
// Ports: clk_i/rst_ni (dest clock, async active-low reset), din_i (async level),
// dout_o (synchronized level), rise_o/fall_o/chg_o (one-cycle pulses).
module cdc_sync_chan
    import cdc_pkg::*;
#(
    parameter int   STAGES    = 3,
    parameter int   FILTER    = 0,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o,
    output logic chg_o
);

    if (!stages_legal(STAGES)) begin : g_bad_stages
        $error("cdc_sync_chan: STAGES=%0d outside legal range %0d..%0d",
               STAGES, STAGES_MIN, STAGES_MAX);
    end

    // Synchronizer chain: bit 0 is the metastability-exposed capture flop.
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              sync_last;
    logic              dout;
    logic              dout_dly_q;

    assign sync_d    = {sync_q[STAGES-2:0], din_i};
    assign sync_last = sync_q[STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    if (FILTER == 0) begin : g_no_filter
        assign dout = sync_last;
    end else begin : g_filter
        localparam int             CW       = cnt_width(FILTER);
        localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          filt_q;
        logic          filt_d;

        // cnt_q counts edges already seen with a differing value; the edge at
        // which it reads FILTER-1 is the FILTER-th consecutive one.
        always_comb begin
            cnt_d  = '0;
            filt_d = filt_q;
            if (sync_last != filt_q) begin
                if (cnt_q == CNT_LAST) begin
                    filt_d = sync_last;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q  <= '0;
                filt_q <= RESET_VAL;
            end else begin
                cnt_q  <= cnt_d;
                filt_q <= filt_d;
            end
        end

        assign dout = filt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dout_dly_q <= RESET_VAL;
        end else begin
            dout_dly_q <= dout;
        end
    end

    // Pulses are combinational from dout so they coincide with the new level.
    assign dout_o = dout;
    assign rise_o = dout & ~dout_dly_q;
    assign fall_o = ~dout & dout_dly_q;
    assign chg_o  = rise_o | fall_o;

endmodule

// File: rtl/cdc_multi_sync.sv
// WIDTH independent destination-domain synchronizers with optional filter and
// edge pulses. No cross-channel coherency: use only for slow control bits.
// Ports: Bclk (dest clock), reset (async active-low), din (async levels),
// dout (synchronized levels), rise/fall/chg (one-cycle per-channel pulses).
module cdc_multi_sync
    import cdc_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               STAGES    = 3,
    parameter int               FILTER    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Bclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] chg
);

    if (WIDTH < 1) begin : g_bad_width
        $error("cdc_multi_sync: WIDTH=%0d must be >= 1", WIDTH);
    end

    if (!stages_legal(STAGES)) begin : g_bad_stages
        $error("cdc_multi_sync: STAGES=%0d outside legal range %0d..%0d",
               STAGES, STAGES_MIN, STAGES_MAX);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        cdc_sync_chan #(
            .STAGES    (STAGES),
            .FILTER    (FILTER),
            .RESET_VAL (RESET_VAL[i])
        ) u_chan (
            .clk_i  (Bclk),
            .rst_ni (reset),
            .din_i  (din[i]),
            .dout_o (dout[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i]),
            .chg_o  (chg[i])
        );
    end

endmodule

// File: tb/tb_cdc_multi_sync.sv
// Scoreboard bench for cdc_multi_sync: four configurations share din/reset.
// A window-based reference model predicts every cycle; a negedge monitor compares.
module tb_cdc_multi_sync;

    localparam int NDUT = 4;
    localparam int ST [NDUT] = '{3, 3, 2, 8};
    localparam int FL [NDUT] = '{0, 4, 0, 1};
    localparam logic [3:0] RV [NDUT] = '{4'h0, 4'h0, 4'h5, 4'hA};

    logic       Bclk;
    logic       reset;
    logic [3:0] din;

    logic [NDUT-1:0][3:0] dout_w;
    logic [NDUT-1:0][3:0] rise_w;
    logic [NDUT-1:0][3:0] fall_w;
    logic [NDUT-1:0][3:0] chg_w;

    cdc_multi_sync #(.WIDTH(4), .STAGES(3), .FILTER(0), .RESET_VAL(4'h0)) u_dut0 (
        .Bclk(Bclk), .reset(reset), .din(din),
        .dout(dout_w[0]), .rise(rise_w[0]), .fall(fall_w[0]), .chg(chg_w[0]));
    cdc_multi_sync #(.WIDTH(4), .STAGES(3), .FILTER(4), .RESET_VAL(4'h0)) u_dut1 (
        .Bclk(Bclk), .reset(reset), .din(din),
        .dout(dout_w[1]), .rise(rise_w[1]), .fall(fall_w[1]), .chg(chg_w[1]));
    cdc_multi_sync #(.WIDTH(4), .STAGES(2), .FILTER(0), .RESET_VAL(4'h5)) u_dut2 (
        .Bclk(Bclk), .reset(reset), .din(din),
        .dout(dout_w[2]), .rise(rise_w[2]), .fall(fall_w[2]), .chg(chg_w[2]));
    cdc_multi_sync #(.WIDTH(4), .STAGES(8), .FILTER(1), .RESET_VAL(4'hA)) u_dut3 (
        .Bclk(Bclk), .reset(reset), .din(din),
        .dout(dout_w[3]), .rise(rise_w[3]), .fall(fall_w[3]), .chg(chg_w[3]));

    initial Bclk = 1'b0;
    always #5 Bclk = ~Bclk;

    // Reference model: history of din captured at each edge since reset release
    // (index 0 = most recent). Anything older than the history is RESET_VAL.
    logic [3:0] cap [$];
    logic [3:0] m_dout [NDUT];
    logic [3:0] m_rise [NDUT];
    logic [3:0] m_fall [NDUT];

    logic [63:0] sb_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit started  = 1'b0;

    function automatic logic [3:0] hist(input int age, input logic [3:0] rv);
        if (age < cap.size()) return cap[age];
        return rv;
    endfunction

    task automatic model_reset();
        cap.delete();
        for (int i = 0; i < NDUT; i++) begin
            m_dout[i] = RV[i];
            m_rise[i] = 4'h0;
            m_fall[i] = 4'h0;
        end
    endtask

    // Synchronized level = din captured STAGES-1 edges ago. With a filter, dout
    // flips only when the synchronized level seen at each of the last FILTER
    // edges disagreed with dout.
    task automatic model_edge();
        logic [3:0] prev, nd, h;
        bit flip;
        if (reset) begin
            cap.push_front(din);
            if (cap.size() > 20) void'(cap.pop_back());
            for (int i = 0; i < NDUT; i++) begin
                prev = m_dout[i];
                if (FL[i] == 0) begin
                    nd = hist(ST[i] - 1, RV[i]);
                end else begin
                    nd = prev;
                    for (int b = 0; b < 4; b++) begin
                        flip = 1'b1;
                        for (int j = 0; j < FL[i]; j++) begin
                            h = hist(ST[i] + j, RV[i]);
                            if (h[b] == prev[b]) flip = 1'b0;
                        end
                        if (flip) nd[b] = ~prev[b];
                    end
                end
                m_rise[i] = nd & ~prev;
                m_fall[i] = ~nd & prev;
                m_dout[i] = nd;
            end
        end
    endtask

    task automatic push_expect();
        logic [63:0] e;
        for (int i = 0; i < NDUT; i++) begin
            e[i*16 +: 16] = {m_dout[i], m_rise[i], m_fall[i], m_rise[i] | m_fall[i]};
        end
        sb_q.push_back(e);
        started = 1'b1;
    endtask

    // One clock: model the edge with the inputs the DUT saw, then change inputs
    // shortly after the edge (reset assertion takes effect mid-cycle).
    task automatic step(input logic [3:0] d, input logic r);
        @(posedge Bclk);
        model_edge();
        #1;
        din   = d;
        reset = r;
        if (!r) model_reset();
        push_expect();
        cyc++;
    endtask

    always @(negedge Bclk) begin
        logic [63:0] ev;
        logic [15:0] act;
        if (started) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow cyc %0d: no expectation queued", cyc);
            end else begin
                ev = sb_q.pop_front();
                for (int i = 0; i < NDUT; i++) begin
                    act = {dout_w[i], rise_w[i], fall_w[i], chg_w[i]};
                    n_checks++;
                    if (act === ev[i*16 +: 16]) begin
                        n_pass++;
                    end else begin
                        $display("FAIL dut%0d cyc %0d dout/rise/fall/chg got %h want %h",
                                 i, cyc, act, ev[i*16 +: 16]);
                    end
                end
            end
        end
    end

    initial begin
        din   = 4'hF;
        reset = 1'b0;
        model_reset();

        // Held in reset with din away from RESET_VAL.
        repeat (4) step(4'hF, 1'b0);
        // Release with din = 0: matches some reset values, not others.
        repeat (16) step(4'h0, 1'b1);
        // Single-channel latency and one rise pulse.
        repeat (14) step(4'h1, 1'b1);
        // Reset asserted mid-cycle while din = F in flight, then held.
        repeat (3) step(4'hF, 1'b1);
        repeat (3) step(4'hF, 1'b0);
        repeat (16) step(4'h0, 1'b1);
        // Short pulse on channel 1, shorter than the filter.
        repeat (3) step(4'h2, 1'b1);
        repeat (16) step(4'h0, 1'b1);
        // Long pulse on channel 1, survives the filter.
        repeat (6) step(4'h2, 1'b1);
        repeat (18) step(4'h0, 1'b1);
        // All channels change together.
        repeat (16) step(4'h5, 1'b1);
        repeat (16) step(4'hA, 1'b1);
        repeat (16) step(4'h0, 1'b1);
        // Reset while the filter is mid-count, release with din[0] still high.
        repeat (5) step(4'h1, 1'b1);
        repeat (2) step(4'h1, 1'b0);
        repeat (18) step(4'h1, 1'b1);
        // Random levels with random hold times and occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            logic [3:0] d;
            int h;
            d = 4'($urandom_range(0, 15));
            h = $urandom_range(1, 7);
            if ($urandom_range(0, 29) == 0) begin
                repeat ($urandom_range(1, 3)) step(d, 1'b0);
            end
            repeat (h) step(d, 1'b1);
        end

        @(negedge Bclk);
        @(posedge Bclk);
        n_checks++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cdc_multi_sync.md
Name: cdc_multi_sync

Overview:
Parametrised multi-bit, destination-domain synchronizer; successor to the fixed single-bit 3-flop CDC chain. Each of WIDTH asynchronous level inputs passes through a STAGES-deep flop chain clocked by the destination clock. An optional per-channel stability filter follows the chain, then registered-edge detection producing one-cycle rise/fall/change pulses. Sits at the receiving boundary of any clock-domain crossing for slow or quasi-static control bits; not for multi-bit data buses needing coherency.

Parameters:
WIDTH, 4, number of independent channels (>=1)
STAGES, 3, synchronizer depth per channel; legal 2..8, anything else is an elaboration error
FILTER, 0, consecutive destination cycles a synchronized change must persist before dout follows; 0 = filter bypassed
RESET_VAL, {WIDTH{1'b0}}, per-channel reset value of chain, filter and edge registers

Ports:
Bclk  input  1  destination clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
din  input  WIDTH  asynchronous level inputs from the source domain
dout  output  WIDTH  synchronized (and filtered) levels
rise  output  WIDTH  one-cycle pulse per channel on dout 0->1
fall  output  WIDTH  one-cycle pulse per channel on dout 1->0
chg  output  WIDTH  rise | fall

Behaviour:
- Reset asserted (reset=0): immediately, without waiting for a clock, all chain stages, filter registers and edge registers = RESET_VAL; filter counters = 0; dout = RESET_VAL; rise = fall = chg = 0. Reset release must be synchronous to Bclk; that is the upstream reset synchronizer's responsibility.
- Chain: stage0 <= din; stage[i] <= stage[i-1]. No logic between stages. Each channel is independent; no cross-channel coherency.
- FILTER=0: dout = last stage. A din change meeting setup before edge k appears on dout after edge k+STAGES-1.
- FILTER=N>0: per-channel counter of clog2(N+1) bits.
  - Last stage differs from dout at an edge: counter increments.
  - Last stage differs at N consecutive edges: dout takes the new value at the Nth edge and the counter clears.
  - Last stage equals dout at any edge: counter clears.
  - Added latency is exactly N cycles. Synchronized pulses shorter than N cycles are discarded.
- Edge detect: dout_d <= dout; rise = dout & ~dout_d; fall = ~dout & dout_d; chg = rise | fall.
  - Pulses are valid in the same cycle dout first shows the new value and last exactly one cycle.
  - Simultaneous changes on several channels give simultaneous pulses.
- Reset mid-operation (chain in flight or filter mid-count): all state returns to reset values and the in-progress change is lost. No pulses are generated by reset itself or by its release.
- din held at RESET_VAL through reset release: no pulses. din differing from RESET_VAL at release: full latency, then one pulse.

Decomposition:
- Shared package cdc_pkg holds:
  - STAGES_MIN = 2 and STAGES_MAX = 8.
  - A clog2 constant function for the filter counter width.
  - The parameter legality check macro/function.
- Sub-module cdc_sync_chan: one channel containing chain, filter counter, dout_d and pulse logic, with STAGES, FILTER and a 1-bit RESET_VAL.
- cdc_multi_sync is a generate loop of WIDTH cdc_sync_chan instances.

Test Plan:
- Reset: WIDTH=4, RESET_VAL=4'h0, din=4'hF, reset driven 0 mid-cycle -> dout=4'h0 and rise/fall/chg=0 before the next Bclk edge; remain so while reset=0.
- Latency: STAGES=3, FILTER=0, din[0] 0->1 before edge k -> dout[0]=1 after edge k+2; rise[0]=1 and chg[0]=1 for exactly that cycle; fall=0.
- Filter: STAGES=3, FILTER=4, din[1] high for 3 Bclk cycles -> dout[1] never changes and no pulses. din[1] high for 6 cycles from edge k -> dout[1]=1 after edge k+6, one rise pulse; falls after edge k+12 with one fall pulse.
- Multi-channel: din 4'b0101 -> 4'b1010 at one edge -> after STAGES edges, rise=4'b1010 and fall=4'b0101 in the same single cycle.
- Reset mid-count: FILTER=4, reset=0 when the counter is at 2 -> dout=RESET_VAL, counter 0. Release with din[0]=1 held -> dout[0]=1 after STAGES-1+4 edges, single rise pulse.
- Parameter sweep: STAGES=2 and STAGES=8 -> measured latency 1 and 7 edges after capture respectively. STAGES=1 or 9 -> elaboration fails.
